// File: rtl/ddr4_cmd_pkg.sv
// ddr4_cmd_pkg: shared FSM states, DDR4 opcodes and bank-index helper for the command sequencer
package ddr4_cmd_pkg;

    typedef enum logic [2:0] {IDLE, ACT, TRCD, CMD, XFER, TRP} state_t;

    localparam logic [2:0] OP_RD  = 3'b101;
    localparam logic [2:0] OP_WR  = 3'b100;
    localparam logic [2:0] OP_PRE = 3'b010;

    function automatic int sync_idx(input int bgv, input int bav, input int bawidth);
        return (bgv << bawidth) | bav;
    endfunction

endpackage

// File: rtl/ddr4_timing_counter.sv
// ddr4_timing_counter: loadable down-counter with zero flag, shared by every timing wait
module ddr4_timing_counter #(
    parameter int W = 5
) (
    input  logic         ck_t,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = cnt == '0;

    // load on state entry, otherwise count down and park at zero
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= value;
        else if (!zero) cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer: closed-page ACT/RD-WR/PRE sequencer with registered DDR4 command pins
module ddr4_cmd_sequencer
    import ddr4_cmd_pkg::*;
#(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int T_RCD     = 17,
    parameter int T_CL      = 17,
    parameter int T_WR      = 14,
    parameter int T_RP      = 17
) (
    input  logic                                     ck_t,
    input  logic                                     reset_n,
    input  logic                                     req_valid,
    output logic                                     req_ready,
    input  logic                                     req_write,
    input  logic [((RANKS > 1) ? $clog2(RANKS) : 1)-1:0] req_rank,
    input  logic [BGWIDTH-1:0]                       req_bg,
    input  logic [BAWIDTH-1:0]                       req_ba,
    input  logic [ADDRWIDTH-1:0]                     req_row,
    input  logic [COLWIDTH-1:0]                      req_col,
    output logic                                     done,
    output logic [RANKS-1:0]                         cs_n,
    output logic                                     act_n,
    output logic [ADDRWIDTH-1:0]                     A,
    output logic [BGWIDTH-1:0]                       bg,
    output logic [BAWIDTH-1:0]                       ba,
    output logic                                     wr_en,
    output logic [$clog2(BL)-1:0]                    wr_beat,
    output logic                                     rd_valid,
    output logic [2**(BGWIDTH+BAWIDTH)-1:0]          sync
);

    localparam int RKW  = (RANKS > 1) ? $clog2(RANKS) : 1;
    localparam int NB   = 2**(BGWIDTH+BAWIDTH);
    localparam int BW   = $clog2(BL);
    localparam int XW   = BL + T_WR;
    localparam int XR   = T_CL + BL;
    localparam int MX1  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int MX2  = (XW > XR) ? XW : XR;
    localparam int MAXW = (MX1 > MX2) ? MX1 : MX2;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BL - 1);

    state_t state, nxt;
    logic                 write_q;
    logic [RKW-1:0]       rank_q, f_rank;
    logic [BGWIDTH-1:0]   bg_q, f_bg, bg_d;
    logic [BAWIDTH-1:0]   ba_q, f_ba, ba_d;
    logic [ADDRWIDTH-1:0] row_q, f_row, a_d;
    logic [COLWIDTH-1:0]  col_q;
    logic [CW-1:0]        ld_val, cnt;
    logic                 load, zero, acc, pre, cmd, act_d, wr_d, rd_d, done_d;
    logic [RANKS-1:0]     cs_d;
    logic [NB-1:0]        mask, sync_d;

    assign req_ready = state == IDLE;
    assign acc       = req_valid && req_ready;
    assign f_rank    = req_ready ? req_rank : rank_q;
    assign f_bg      = req_ready ? req_bg : bg_q;
    assign f_ba      = req_ready ? req_ba : ba_q;
    assign f_row     = req_ready ? req_row : row_q;
    assign load      = nxt != state;
    assign ld_val    = nxt == TRCD ? CW'(T_RCD - 2) :
                       nxt == XFER ? (write_q ? CW'(XW - 2) : CW'(XR - 2)) :
                       nxt == TRP  ? CW'(T_RP - 1) : '0;

    ddr4_timing_counter #(.W(CW)) u_cnt (
        .ck_t(ck_t), .reset_n(reset_n), .load(load), .value(ld_val), .cnt(cnt), .zero(zero)
    );

    // capture the request on accept so later input changes are ignored
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            rank_q  <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (acc) begin
            write_q <= req_write;
            rank_q  <= req_rank;
            bg_q    <= req_bg;
            ba_q    <= req_ba;
            row_q   <= req_row;
            col_q   <= req_col;
        end
    end

    // state register
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    end

    // next state: every timed wait exits when the shared counter reaches zero
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? ACT : IDLE;
            ACT:     nxt = TRCD;
            TRCD:    nxt = zero ? CMD : TRCD;
            CMD:     nxt = XFER;
            XFER:    nxt = zero ? TRP : XFER;
            TRP:     nxt = zero ? IDLE : TRP;
            default: nxt = IDLE;
        endcase
    end

    // pin values for the coming cycle, derived from the state being entered
    always_comb begin
        pre    = nxt == TRP && state != TRP;
        cmd    = nxt == ACT || nxt == CMD || pre;
        cs_d   = cmd ? ~(RANKS'(1) << f_rank) : '1;
        act_d  = nxt != ACT;
        a_d    = nxt == ACT ? f_row :
                 nxt == CMD ? ADDRWIDTH'({write_q ? OP_WR : OP_RD, 14'(col_q)}) :
                 pre        ? ADDRWIDTH'({OP_PRE, 14'd0}) : '0;
        bg_d   = cmd ? f_bg : bg;
        ba_d   = cmd ? f_ba : ba;
        mask   = NB'(1) << sync_idx(int'(f_bg), int'(f_ba), BAWIDTH);
        sync_d = nxt == ACT ? (sync | mask) : pre ? (sync & ~mask) : sync;
        wr_d   = (nxt == CMD && write_q) || (wr_en && wr_beat != BEAT_LAST);
        rd_d   = !write_q && ((state == XFER && cnt != '0 && cnt <= CW'(BL)) ||
                              (state == CMD && T_CL == 1));
        done_d = state == TRP && nxt == IDLE;
    end

    // registered pin drivers; wr_beat free-runs only while the burst is enabled
    always_ff @(posedge ck_t or negedge reset_n) begin
        if (!reset_n) begin
            cs_n     <= '1;
            act_n    <= 1'b1;
            A        <= '0;
            bg       <= '0;
            ba       <= '0;
            wr_en    <= 1'b0;
            wr_beat  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            sync     <= '0;
        end else begin
            cs_n     <= cs_d;
            act_n    <= act_d;
            A        <= a_d;
            bg       <= bg_d;
            ba       <= ba_d;
            wr_en    <= wr_d;
            wr_beat  <= wr_en ? wr_beat + 1'b1 : '0;
            rd_valid <= rd_d;
            done     <= done_d;
            sync     <= sync_d;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// tb_ddr4_cmd_sequencer: scoreboard bench comparing every pin, every cycle, against the request timeline
module tb_ddr4_cmd_sequencer;

    localparam int T_RCD = 17, T_CL = 17, T_WR = 14, T_RP = 17, BL = 8;

    logic        ck_t = 1'b0, reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [0:0]  req_rank = 1'b0;
    logic [1:0]  req_bg = '0, req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        req_ready, done, act_n, wr_en, rd_valid;
    logic [0:0]  cs_n;
    logic [16:0] A;
    logic [1:0]  bg, ba;
    logic [2:0]  wr_beat;
    logic [15:0] sync;

    ddr4_cmd_sequencer dut (
        .ck_t(ck_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_rank(req_rank), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .done(done), .cs_n(cs_n), .act_n(act_n),
        .A(A), .bg(bg), .ba(ba), .wr_en(wr_en), .wr_beat(wr_beat), .rd_valid(rd_valid),
        .sync(sync)
    );

    always #5 ck_t = ~ck_t;

    int errors = 0, checks = 0, cyc = 0;
    int q_cyc[$];
    int q_k[$];
    logic [63:0] q_sig[$];
    logic        acc_nxt = 1'b0, a_w = 1'b0;
    logic [1:0]  a_bg = '0, a_ba = '0;
    logic [16:0] a_row = '0;
    logic [9:0]  a_col = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic c, input logic an, input logic [16:0] a,
                                         input logic [1:0] g, input logic [1:0] b, input logic we,
                                         input logic [2:0] wb, input logic rv, input logic dn,
                                         input logic rdy, input logic [15:0] s);
        return {18'd0, c, an, a, g, b, we, wb, rv, dn, rdy, s};
    endfunction

    // expected pins for spec cycles c1..done of one request; c_k is observed after edge e0+k-1
    task automatic push_req(input int e0, input logic w, input logic [1:0] g, input logic [1:0] b,
                            input logic [16:0] row, input logic [9:0] col);
        int wc, pre, dn;
        logic [16:0] a;
        logic we, rv;
        logic [2:0] wb;
        logic [15:0] s;
        wc  = 1 + T_RCD;
        pre = w ? wc + BL + T_WR : wc + T_CL + BL;
        dn  = pre + T_RP;
        for (int k = 1; k <= dn; k++) begin
            we = w && k >= wc && k < wc + BL;
            wb = we ? 3'(k - wc) : 3'd0;
            rv = !w && k >= wc + T_CL && k < wc + T_CL + BL;
            a  = k == 1 ? row : k == wc ? {w ? 3'b100 : 3'b101, 4'd0, col} :
                 k == pre ? 17'h08000 : 17'd0;
            s  = k < pre ? 16'd1 << {g, b} : 16'd0;
            q_cyc.push_back(e0 + k - 1);
            q_k.push_back(k);
            q_sig.push_back(pack(!(k == 1 || k == wc || k == pre), k != 1, a, g, b, we, wb, rv,
                                 k == dn, k == dn, s));
        end
    endtask

    initial forever begin
        @(negedge ck_t);
        acc_nxt = req_valid && req_ready && reset_n;
        a_w = req_write;
        a_bg = req_bg;
        a_ba = req_ba;
        a_row = req_row;
        a_col = req_col;
    end

    initial forever begin
        @(posedge ck_t);
        #1;
        cyc++;
        if (acc_nxt) push_req(cyc, a_w, a_bg, a_ba, a_row, a_col);
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            check($sformatf("%s c%0d", a_w ? "wr" : "rd", q_k[0]),
                  pack(cs_n[0], act_n, A, bg, ba, wr_en, wr_beat, rd_valid, done, req_ready, sync),
                  q_sig[0]);
            void'(q_cyc.pop_front());
            void'(q_k.pop_front());
            void'(q_sig.pop_front());
        end
    end

    task automatic wait_acc();
        int n = 0;
        do begin
            @(negedge ck_t);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) check("accept timeout", 0, 1);
        @(posedge ck_t);
    endtask

    task automatic send(input logic w, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] row, input logic [9:0] col);
        @(posedge ck_t);
        #2;
        req_write = w;
        req_bg = g;
        req_ba = b;
        req_row = row;
        req_col = col;
        req_valid = 1'b1;
        wait_acc();
        #2;
        req_valid = 1'b0;
        req_write = !w;
        req_bg = ~g;
        req_ba = ~b;
        req_row = ~row;
        req_col = ~col;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        do begin
            @(posedge ck_t);
            #1;
            k++;
        end while (!done && k < 300);
        if (!done) check("done timeout", 0, 1);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, " cs_n"}, cs_n, 1);
        check({tag, " act_n"}, act_n, 1);
        check({tag, " A"}, A, 0);
        check({tag, " sync"}, sync, 0);
        check({tag, " ready"}, req_ready, 1);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " wr_beat"}, wr_beat, 0);
        check({tag, " rd_valid"}, rd_valid, 0);
        check({tag, " done"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [3:0] p;
        repeat (3) @(posedge ck_t);
        #1;
        check_reset_pins("in reset");
        check("in reset bg", {bg, ba}, 0);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge ck_t);
        #1;
        check_reset_pins("after reset");

        send(1'b1, 2'd1, 2'd1, 17'd1, 10'd2);
        wait_done(k);
        check("write done cycle", k, 57);

        send(1'b0, 2'd1, 2'd1, 17'd4, 10'd2);
        wait_done(k);
        check("read done cycle", k, 60);

        @(posedge ck_t);
        #2;
        req_write = 1'b0;
        req_bg = 2'd2;
        req_ba = 2'd3;
        req_row = 17'h1abcd;
        req_col = 10'h155;
        req_valid = 1'b1;
        wait_acc();
        #2;
        req_write = 1'b1;
        req_bg = 2'd0;
        req_ba = 2'd2;
        req_row = 17'h00f0f;
        req_col = 10'h3ff;
        wait_done(k);
        check("b2b first done", k, 60);
        @(negedge ck_t);
        check("b2b ready", req_ready, 1);
        @(posedge ck_t);
        #1;
        check("b2b act", act_n, 0);
        #1;
        req_valid = 1'b0;
        wait_done(k);
        check("b2b second done", k, 57);

        send(1'b1, 2'd3, 2'd0, 17'h12345, 10'h0aa);
        repeat (19) @(posedge ck_t);
        #3;
        check("pre-reset wr_en", wr_en, 1);
        check("pre-reset sync", sync, 16'h1000);
        reset_n = 1'b0;
        q_cyc.delete();
        q_k.delete();
        q_sig.delete();
        #1;
        check_reset_pins("async reset");
        check("async reset bg", {bg, ba}, 0);
        repeat (2) @(posedge ck_t);
        #2;
        reset_n = 1'b1;
        send(1'b0, 2'd1, 2'd2, 17'h0beef, 10'h321);
        wait_done(k);
        check("post-reset read done", k, 60);

        for (int i = 0; i < 16; i++) begin
            p = 4'(i);
            send(p[0], p[3:2], p[1:0], 17'($urandom), 10'($urandom));
            wait_done(k);
            check($sformatf("sweep %0d done", i), k, p[0] ? 57 : 60);
        end

        repeat (2) @(posedge ck_t);
        #2;
        check("scoreboard drained", q_cyc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
